// File: rtl/sd4_pkg.sv
// Shared definitions for the sd4_mac job controller: field widths, default MAC
// pipeline latency and the sequencer state encoding.
package sd4_pkg;

    localparam int SD4_W_BITS  = 4;
    localparam int PIX_BITS    = 8;
    localparam int TAPS        = 9;
    localparam int FP16_BITS   = 16;
    localparam int MAC_LAT_DEF = 4;

    localparam int WIN_BITS = PIX_BITS * TAPS;
    localparam int KER_BITS = SD4_W_BITS * TAPS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/sd4_res_fifo.sv
// Synchronous result FIFO holding {last, data} entries; exposes its fill count
// so the sequencer can meter window issue against free space.
module sd4_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;

    // The writer is credit-limited upstream, so a push never meets a full FIFO.
    assign w_pop_ok = i_pop && (r_count != '0);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_empty  = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sd4_mac_sequencer.sv
// Job controller for one sd4_mac: latches the kernel, streams windows into the
// MAC, tracks in-flight results with a valid pipe and queues them for output.
import sd4_pkg::*;

module sd4_mac_sequencer #(
    parameter int MAC_LAT    = MAC_LAT_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cfg_num_win,
    input  logic [4:0]                   cfg_exp_bias,
    output logic                         busy,
    output logic                         done,
    input  logic                         w_valid,
    input  logic [KER_BITS-1:0]          w_data,
    output logic                         w_ready,
    input  logic                         win_valid,
    input  logic [WIN_BITS-1:0]          win_data,
    output logic                         win_ready,
    output logic [WIN_BITS-1:0]          mac_image,
    output logic [KER_BITS-1:0]          mac_weight,
    output logic [4:0]                   mac_exp_bias,
    input  logic [FP16_BITS-1:0]         mac_out,
    output logic                         res_valid,
    output logic [FP16_BITS-1:0]         res_data,
    output logic                         res_last,
    input  logic                         res_ready,
    output logic [2:0]                   dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]  dbg_fifo_count
);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = $clog2(MAC_LAT + FIFO_DEPTH + 1);

    // Handshakes: a word moves on a rising edge where valid & ready are both high;
    // valid never waits on ready, and res_data is held stable while res_valid waits.
    seq_state_t          r_state;
    logic [CNT_W-1:0]    r_num_win;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_retired;
    logic [MAC_LAT-1:0]  r_pipe;
    logic [WIN_BITS-1:0] r_mac_image;
    logic [KER_BITS-1:0] r_mac_weight;
    logic [4:0]          r_exp_bias;

    logic [FC_W-1:0]     w_fifo_count;
    logic                w_fifo_empty;
    logic [FP16_BITS:0]  w_head;
    logic [OCC_W-1:0]    w_inflight;
    logic [OCC_W-1:0]    w_occupancy;
    logic                w_win_ready;
    logic                w_win_accept;
    logic                w_push;
    logic                w_push_last;
    logic                w_pop;
    logic                w_drain_done;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MAC_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(r_pipe[i]);
        end
    end

    // Issue only when every in-flight result already has a FIFO slot reserved.
    assign w_occupancy  = w_inflight + OCC_W'(w_fifo_count);
    assign w_win_ready  = (r_state == S_RUN) && (r_issued < r_num_win) &&
                          (w_occupancy < OCC_W'(FIFO_DEPTH));
    assign w_win_accept = win_valid && w_win_ready;
    assign w_push       = r_pipe[MAC_LAT-1];
    assign w_push_last  = ((r_retired + CNT_W'(1)) == r_num_win);
    assign w_pop        = !w_fifo_empty && res_ready;
    // Leave DRAIN on the edge that pops the final result so done follows at once.
    assign w_drain_done = (r_retired == r_num_win) &&
                          ((w_fifo_count == '0) || ((w_fifo_count == FC_W'(1)) && w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_num_win    <= '0;
            r_issued     <= '0;
            r_retired    <= '0;
            r_pipe       <= '0;
            r_mac_image  <= '0;
            r_mac_weight <= '0;
            r_exp_bias   <= '0;
        end else begin
            r_mac_image <= w_win_accept ? win_data : '0;
            r_pipe      <= {r_pipe[MAC_LAT-2:0], w_win_accept};
            if (w_win_accept) begin
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_push) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_win  <= cfg_num_win;
                        r_exp_bias <= cfg_exp_bias;
                        r_issued   <= '0;
                        r_retired  <= '0;
                        r_state    <= (cfg_num_win == '0) ? S_DONE : S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        r_mac_weight <= w_data;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_issued == r_num_win) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    sd4_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FP16_BITS + 1)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({w_push_last, mac_out}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign w_ready        = (r_state == S_LOAD_W);
    assign win_ready      = w_win_ready;
    assign mac_image      = r_mac_image;
    assign mac_weight     = r_mac_weight;
    assign mac_exp_bias   = r_exp_bias;
    assign res_valid      = !w_fifo_empty;
    assign res_data       = w_head[FP16_BITS-1:0];
    assign res_last       = w_head[FP16_BITS];
    assign dbg_state      = r_state;
    assign dbg_fifo_count = w_fifo_count;

endmodule

// File: tb/tb_sd4_mac_sequencer.sv
// Directed bench for sd4_mac_sequencer with a behavioural MAC and an
// in-order result scoreboard.
module tb_sd4_mac_sequencer;
    import sd4_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  cfg_num_win;
    logic [4:0]   cfg_exp_bias;
    logic         busy, done;
    logic         w_valid;
    logic [35:0]  w_data;
    logic         w_ready;
    logic         win_valid;
    logic [71:0]  win_data;
    logic         win_ready;
    logic [71:0]  mac_image;
    logic [35:0]  mac_weight;
    logic [4:0]   mac_exp_bias;
    logic [15:0]  mac_out;
    logic         res_valid;
    logic [15:0]  res_data;
    logic         res_last;
    logic         res_ready;
    logic [2:0]   dbg_state;
    logic [2:0]   dbg_fifo_count;

    always #5 clk = ~clk;

    sd4_mac_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_win    (cfg_num_win),
        .cfg_exp_bias   (cfg_exp_bias),
        .busy           (busy),
        .done           (done),
        .w_valid        (w_valid),
        .w_data         (w_data),
        .w_ready        (w_ready),
        .win_valid      (win_valid),
        .win_data       (win_data),
        .win_ready      (win_ready),
        .mac_image      (mac_image),
        .mac_weight     (mac_weight),
        .mac_exp_bias   (mac_exp_bias),
        .mac_out        (mac_out),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_last       (res_last),
        .res_ready      (res_ready),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // Behavioural MAC: the result for an image appears MAC_LAT edges after it.
    logic [71:0] mac_model [0:2];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) mac_model[i] <= '0;
        end else begin
            mac_model[0] <= mac_image;
            mac_model[1] <= mac_model[0];
            mac_model[2] <= mac_model[1];
        end
    end
    assign mac_out = mac_model[2][15:0] ^ mac_weight[15:0] ^ {11'd0, mac_exp_bias};

    function automatic logic [15:0] f_model(input logic [71:0] w, input logic [35:0] k,
                                            input logic [4:0] b);
        return w[15:0] ^ k[15:0] ^ {11'd0, b};
    endfunction

    typedef struct {
        logic [71:0] win;
        logic [15:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t         basic_tbl [3];
    logic [16:0]  exp_q [$];
    logic [16:0]  got_q [$];
    logic [71:0]  src [0:31];
    logic [35:0]  job_w;
    logic [4:0]   job_b;
    int           job_n, sent, n_pop, n_done;
    int           first_acc, first_res, last_pop, done_cyc, max_cnt, res_seen;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    bit           auto_win = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: score the handshakes of the current cycle, then advance.
    task automatic tick();
        logic [16:0] got;
        if (res_valid && res_ready) begin
            got = {res_last, res_data};
            got_q.push_back(got);
            n_pop++;
            if (res_last) last_pop = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0h, expected none (cycle %0d)", got, cyc);
            end else begin
                chk("result", 80'(got), 80'(exp_q.pop_front()));
            end
        end
        if (win_valid && win_ready) begin
            if (sent == 0) first_acc = cyc;
            exp_q.push_back({(sent == job_n - 1), f_model(src[sent], job_w, job_b)});
            sent++;
        end
        if (res_valid && first_res < 0) first_res = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (int'(dbg_fifo_count) > max_cnt) max_cnt = int'(dbg_fifo_count);
        @(posedge clk);
        #1;
        cyc++;
        if (auto_win && sent < job_n && sent < 32) begin
            win_valid = 1'b1;
            win_data  = src[sent];
        end else begin
            win_valid = 1'b0;
            win_data  = '0;
        end
    endtask

    task automatic prep_job(input int n, input logic [4:0] b, input logic [35:0] k);
        job_n = n; job_b = b; job_w = k;
        sent = 0; n_pop = 0; n_done = 0; max_cnt = 0;
        first_acc = -1; first_res = -1; last_pop = -1; done_cyc = -1;
        got_q.delete();
        for (int i = 0; i < 32; i++) begin
            src[i] = {8'(i), 48'h5A5A_0000_C3C3, 16'(16'h1111 * i + 16'h0042)};
        end
    endtask

    task automatic pulse_start();
        start        = 1'b1;
        cfg_num_win  = 16'(job_n);
        cfg_exp_bias = job_b;
        tick();
        start = 1'b0;
    endtask

    task automatic load_kernel();
        w_valid = 1'b1;
        w_data  = job_w;
        tick();
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (n_done == 0 && t < budget) begin
            tick();
            t++;
        end
        if (n_done == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        basic_tbl[0] = '{72'h11_2233_4455_6677_0001, 16'h6787, 1'b0};
        basic_tbl[1] = '{72'hAA_BBCC_DDEE_FF00_1000, 16'h7786, 1'b0};
        basic_tbl[2] = '{72'h01_0203_0405_0607_FFFF, 16'h9879, 1'b1};

        rst = 1'b1; start = 1'b0; cfg_num_win = '0; cfg_exp_bias = '0;
        w_valid = 1'b0; w_data = '0; win_valid = 1'b0; win_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_w_ready", 80'(w_ready), 80'(0));
        chk("rst_win_ready", 80'(win_ready), 80'(0));
        chk("rst_res_valid", 80'(res_valid), 80'(0));
        chk("rst_res_last", 80'(res_last), 80'(0));
        chk("rst_outputs", {mac_image, mac_weight[7:0]}, 80'(0));
        chk("rst_bias_data", 80'({mac_exp_bias, res_data}), 80'(0));
        rst = 1'b0;

        // Basic 3-window job with hand-computed results
        prep_job(3, 5'd15, 36'h1_2345_6789);
        for (int i = 0; i < 3; i++) src[i] = basic_tbl[i].win;
        auto_win = 1'b1; res_ready = 1'b1;
        pulse_start();
        chk("basic_busy", 80'(busy), 80'(1));
        chk("basic_w_ready", 80'(w_ready), 80'(1));
        chk("basic_win_ready_loadw", 80'(win_ready), 80'(0));
        load_kernel();
        chk("basic_state_run", 80'(dbg_state), 80'(S_RUN));
        chk("basic_weight", 80'(mac_weight), 80'(36'h1_2345_6789));
        chk("basic_bias", 80'(mac_exp_bias), 80'(5'd15));
        wait_done(60);
        chk("basic_busy_after", 80'(busy), 80'(0));
        chk("basic_latency", 80'(first_res - first_acc), 80'(5));
        chk("basic_done_delay", 80'(done_cyc - last_pop), 80'(1));
        chk("basic_n_pop", 80'(n_pop), 80'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("basic_tbl_%0d", i), 80'(got_q[i]),
                80'({basic_tbl[i].exp_last, basic_tbl[i].exp_data}));
        end

        // Zero-length job
        prep_job(0, 5'd2, 36'h0);
        pulse_start();
        chk("zero_done", 80'(done), 80'(1));
        chk("zero_w_ready", 80'(w_ready), 80'(0));
        tick();
        chk("zero_done_low", 80'(done), 80'(0));
        chk("zero_busy_low", 80'(busy), 80'(0));
        chk("zero_no_results", 80'(n_pop), 80'(0));

        // Back-pressure: result port stalled, issue stops at FIFO depth
        prep_job(10, 5'd3, 36'hA_BCDE_F012);
        res_ready = 1'b0;
        pulse_start();
        load_kernel();
        repeat (30) tick();
        chk("bp_accepted", 80'(sent), 80'(4));
        chk("bp_win_ready", 80'(win_ready), 80'(0));
        chk("bp_fifo_full", 80'(dbg_fifo_count), 80'(4));
        res_ready = 1'b1;
        wait_done(200);
        chk("bp_n_pop", 80'(n_pop), 80'(10));
        chk("bp_last_flag", 80'(got_q[9][16]), 80'(1));
        chk("bp_exp_empty", 80'(exp_q.size()), 80'(0));

        // Alternating res_ready: simultaneous push/pop around a full FIFO
        prep_job(12, 5'd31, 36'h5_5AA5_3C3C);
        pulse_start();
        load_kernel();
        begin
            int t = 0;
            while (n_done == 0 && t < 300) begin
                res_ready = ((cyc % 2) == 1);
                tick();
                t++;
            end
            if (n_done == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL toggle_timeout: got no done, expected done within 300 cycles");
            end
        end
        res_ready = 1'b1;
        chk("toggle_max_count", 80'(max_cnt <= 4), 80'(1));
        chk("toggle_n_pop", 80'(n_pop), 80'(12));
        chk("toggle_exp_empty", 80'(exp_q.size()), 80'(0));

        // Reset with two results in flight
        prep_job(6, 5'd7, 36'h0_F0F0_1234);
        pulse_start();
        load_kernel();
        begin
            int t = 0;
            while (sent < 2 && t < 20) begin
                tick();
                t++;
            end
        end
        auto_win = 1'b0; win_valid = 1'b0; win_data = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 80'(busy), 80'(0));
        chk("mid_rst_flags", 80'({done, w_ready, win_ready, res_valid, res_last}), 80'(0));
        chk("mid_rst_image", 80'(mac_image), 80'(0));
        chk("mid_rst_kernel", 80'({mac_weight, mac_exp_bias, res_data}), 80'(0));
        chk("mid_rst_state", 80'(dbg_state), 80'(S_IDLE));
        exp_q.delete();
        res_seen = 0;
        repeat (10) begin
            if (res_valid) res_seen++;
            tick();
        end
        chk("mid_rst_no_res", 80'(res_seen), 80'(0));
        prep_job(3, 5'd9, 36'h3_0000_7777);
        auto_win = 1'b1;
        pulse_start();
        load_kernel();
        wait_done(60);
        chk("post_rst_n_pop", 80'(n_pop), 80'(3));
        chk("post_rst_exp_empty", 80'(exp_q.size()), 80'(0));

        // Ignored inputs: win_valid in LOAD_W, start and w_valid in RUN
        prep_job(2, 5'd12, 36'h2_1111_2222);
        pulse_start();
        tick();
        chk("ign_state_loadw", 80'(dbg_state), 80'(S_LOAD_W));
        chk("ign_win_ready_loadw", 80'(win_ready), 80'(0));
        chk("ign_no_issue", 80'({32'(sent), 48'(mac_image[47:0])}), 80'(0));
        load_kernel();
        auto_win = 1'b0; win_valid = 1'b0; win_data = '0;
        start = 1'b1; cfg_num_win = 16'd7; cfg_exp_bias = 5'd1;
        w_valid = 1'b1; w_data = 36'hF_FFFF_FFFF;
        tick();
        start = 1'b0; w_valid = 1'b0; w_data = '0;
        chk("ign_state_run", 80'(dbg_state), 80'(S_RUN));
        chk("ign_weight", 80'(mac_weight), 80'(36'h2_1111_2222));
        chk("ign_bias", 80'(mac_exp_bias), 80'(5'd12));
        chk("ign_win_ready_run", 80'(win_ready), 80'(1));
        auto_win = 1'b1; win_valid = 1'b1; win_data = src[sent];
        wait_done(60);
        chk("ign_n_pop", 80'(n_pop), 80'(2));
        chk("ign_last_flag", 80'({got_q[0][16], got_q[1][16]}), 80'(2'b01));
        chk("ign_exp_empty", 80'(exp_q.size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
